// File: rtl/ntt_pkg.sv
// Shared constants and coefficient types for the NTT datapath over Z_3329.
package ntt_pkg;
    localparam int unsigned Q         = 3329;
    localparam int unsigned W         = 12;
    localparam int unsigned BARRETT_M = 5039;
    localparam int unsigned BARRETT_K = 24;

    typedef logic [W-1:0]   coeff_t;
    typedef logic [2*W-1:0] prod_t;
endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 24-bit product into [0, Q-1].
module barrett_reduce
    import ntt_pkg::*;
(
    input  logic [2*W-1:0] p,
    output logic [W-1:0]   r
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned XW = PW + 13;
    localparam int unsigned RW = W + 1;

    logic [XW-1:0] pm;
    logic [12:0]   t;
    logic [PW-1:0] tq;
    logic [RW-1:0] r0;

    // Quotient estimate is at most one short, so a single conditional subtract suffices.
    always_comb begin
        pm = XW'(p) * XW'(BARRETT_M);
        t  = 13'(pm >> BARRETT_K);
        tq = PW'(XW'(t) * XW'(Q));
        r0 = RW'(p - tq);
        r  = (r0 >= RW'(Q)) ? W'(r0 - RW'(Q)) : W'(r0);
    end
endmodule

// File: rtl/gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly: add/sub, multiply by twiddle, Barrett reduce.
module gs_butterfly
    import ntt_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] zeta,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);
    localparam int unsigned SW = W + 1;
    localparam int unsigned PW = 2 * W;

    logic          en;
    logic [SW-1:0] sum;
    coeff_t        s_c;
    coeff_t        d_c;
    prod_t         p_c;
    coeff_t        r_c;

    logic          v1;
    coeff_t        s1_s;
    coeff_t        s1_d;
    coeff_t        s1_z;
    logic          v2;
    prod_t         s2_p;
    coeff_t        s2_s;

    // Whole pipeline stalls only when the output slot is full and not being taken.
    assign en       = !out_valid || out_ready;
    assign in_ready = rst_n && en;

    always_comb begin
        sum = SW'(a) + SW'(b);
        s_c = (sum >= SW'(Q)) ? W'(sum - SW'(Q)) : W'(sum);
        d_c = (a < b) ? W'(SW'(a) + SW'(Q) - SW'(b)) : W'(a - b);
        p_c = PW'(s1_d) * PW'(s1_z);
    end

    barrett_reduce u_barrett (
        .p (s2_p),
        .r (r_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_s      <= '0;
            s1_d      <= '0;
            s1_z      <= '0;
            v2        <= 1'b0;
            s2_p      <= '0;
            s2_s      <= '0;
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else if (en) begin
            v1        <= in_valid;
            s1_s      <= s_c;
            s1_d      <= d_c;
            s1_z      <= zeta;
            v2        <= v1;
            s2_p      <= p_c;
            s2_s      <= s1_s;
            out_valid <= v2;
            a_out     <= s2_s;
            b_out     <= r_c;
        end
    end
endmodule
